xor_checksum_acc: RTL and testbench
===================================

Name: xor_checksum_acc

Overview:
- Sequential consumer stage wrapped around the 4-bit quad-XOR gate model (ls7486).
- Accepts a stream of WIDTH-bit words over a valid/ready handshake and folds each word into a running XOR accumulator, starting from a seed value.
- Reports the checksum after a programmed number of words.
- Used for parity/checksum generation on data moving through the datapath. The XOR itself is performed by WIDTH/4 ls7486 instances (a = accumulator, b = incoming word).

Parameters:
- WIDTH, 4, data/accumulator width; must be a non-zero multiple of 4 (one ls7486 per nibble). Other values are a compile-time error.
- LEN_W, 4, width of the word-count fields; maximum run length 2^LEN_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset.
- start  input  1  begin a run; sampled only in IDLE.
- len  input  LEN_W  number of words in the run; sampled with start.
- seed  input  WIDTH  initial accumulator value; sampled with start.
- in_valid  input  1  upstream word valid.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  block can accept a word this cycle.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse: checksum final.
- checksum  output  WIDTH  accumulator value.
- count  output  LEN_W  words accepted in the current/last run.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. rst_n low immediately forces state=IDLE and clears checksum, count, len register, busy, done and in_ready to 0, including mid-run. All state updates occur on the rising clk edge.
- States: IDLE, RUN, DONE (2-bit register). Outputs decode from registered state only:
  - in_ready = (state==RUN)
  - busy = (state==RUN)
  - done = (state==DONE)
- IDLE:
  - On start=1: acc<=seed, count<=0, len_r<=len.
  - Next state is RUN if len!=0; if len==0 it is DONE, with checksum=seed.
  - start=0: hold. Accumulator and count keep their last values, so checksum stays readable after a run.
- RUN:
  - A transfer occurs when in_valid && in_ready at the clock edge: acc<=acc XOR in_data (through the ls7486 outputs), count<=count+1.
  - When count+1==len_r on a transfer, the next state is DONE.
  - in_valid=0: no change. Gaps of any length are allowed.
  - in_data is don't-care when in_valid=0.
- DONE:
  - Lasts exactly one cycle with done=1 and in_ready=0, then returns to IDLE.
  - The final checksum is visible on checksum in this cycle and held afterwards.
- start handling: start is ignored in RUN and DONE. It is not queued, and asserting it there has no effect.
- Latency:
  - start to first in_ready: 1 cycle.
  - Last accepted word to done: 1 cycle.
  - checksum updates in the cycle after each transfer.
- Width and wrap rules:
  - count never wraps, because the run ends at len_r ≤ 2^LEN_W-1.
  - XOR is bitwise, with no carry; checksum width equals WIDTH.
- Simultaneous events: rst_n low overrides everything. A transfer on the final word and in_valid held high still produce exactly len_r transfers, because in_ready drops in DONE.

Test Plan:
1. Reset: rst_n=0 asynchronously between edges, with the block in RUN and any inputs -> checksum=0000, count=0, busy=0, done=0, in_ready=0 without waiting for a clock edge.
2. Basic XOR: seed=0000, len=2; words 1010 then 0101 back-to-back -> checksum=1010 after the first transfer, 1111 after the second; done high for exactly 1 cycle, the cycle after the second transfer; count=2; busy high for exactly 2 cycles.
3. Seeded run: seed=1111, len=1, word 1010 -> checksum=0101, done one cycle after the transfer, in_ready low in that same cycle; checksum still 0101 five cycles later in IDLE.
4. Zero length: seed=0110, len=0, start pulse -> DONE the next cycle, checksum=0110, count=0, in_ready never asserted.
5. Handshake gaps and ignored start: seed=0000, len=3; words 0001, 0010, 0100 with in_valid low for 2 cycles between words; start pulsed while in RUN -> checksum=0111, exactly 3 transfers, single done pulse, no restart.
6. Reset mid-run: seed=0000, len=3, one word 1100 accepted; then rst_n low for 1 cycle and released -> state IDLE, checksum=0000, count=0. A subsequent start with seed=0011, len=1, word 0001 gives checksum=0010.

Source files
------------

// File: rtl/xor_checksum_acc.sv
// ---------------------------------------------------------------------------
// xor_checksum_acc
//   Streaming XOR checksum stage. A run is armed with start/len/seed in IDLE.
//   The block then accepts len words over a valid/ready handshake and folds
//   each word into a running XOR accumulator. A one-cycle done pulse marks
//   the final checksum, which stays readable after the run.
//   The XOR datapath is a bank of WIDTH/4 ls7486 quad-XOR gate models.
//
// Ports (xor_checksum_acc)
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      begin a run (sampled in IDLE only)
//   len       in   LEN_W  words in the run (sampled with start)
//   seed      in   WIDTH  initial accumulator value (sampled with start)
//   in_valid  in   1      upstream word valid
//   in_data   in   WIDTH  upstream word
//   in_ready  out  1      word accepted this cycle when in_valid is high
//   busy      out  1      run in progress
//   done      out  1      one-cycle pulse, checksum is final
//   checksum  out  WIDTH  accumulator value
//   count     out  LEN_W  words accepted in the current/last run
//
// Ports (ls7486)
//   a, b      in   4      gate inputs
//   y         out  4      y = a ^ b
// ---------------------------------------------------------------------------

module ls7486 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);
  assign y = a ^ b;
endmodule

module xor_checksum_acc #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] seed,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] checksum,
  output logic [LEN_W-1:0] count
);

  // One gate model per nibble, so the width has to split evenly.
  generate
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
      $error("xor_checksum_acc: WIDTH must be a non-zero multiple of 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg;
  logic [LEN_W-1:0] count_reg;
  logic [LEN_W-1:0] len_reg;
  logic [WIDTH-1:0] xor_y;
  logic [LEN_W-1:0] count_inc;
  logic             xfer;

  // XOR datapath: accumulator against the incoming word, nibble by nibble.
  generate
    for (genvar gi = 0; gi < WIDTH / 4; gi++) begin : g_xor
      ls7486 u_ls7486 (
        .a (acc_reg[gi*4 +: 4]),
        .b (in_data[gi*4 +: 4]),
        .y (xor_y[gi*4 +: 4])
      );
    end
  endgenerate

  assign count_inc = count_reg + 1'b1;
  assign xfer      = in_valid && (state_reg == S_RUN);

  // Handshake and status decode purely from the registered state.
  assign in_ready = (state_reg == S_RUN);
  assign busy     = (state_reg == S_RUN);
  assign done     = (state_reg == S_DONE);
  assign checksum = acc_reg;
  assign count    = count_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          // A zero-length run completes immediately with checksum = seed.
          state_next = (len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (xfer && (count_inc == len_reg)) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      acc_reg   <= '0;
      count_reg <= '0;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            acc_reg   <= seed;
            count_reg <= '0;
            len_reg   <= len;
          end
        end
        S_RUN: begin
          if (xfer) begin
            acc_reg   <= xor_y;
            count_reg <= count_inc;
          end
        end
        default: begin
          // DONE and any stray encoding: hold the result.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_checksum_acc.sv
module tb_xor_checksum_acc;

  localparam int WIDTH = 4;
  localparam int LEN_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] seed;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] checksum;
  logic [LEN_W-1:0] count;

  int total = 0;
  int bad   = 0;

  // Edge monitors (counted at the rising edge, inputs are stable there).
  int xfer_cnt  = 0;
  int done_cnt  = 0;
  int busy_cnt  = 0;
  int ready_cnt = 0;

  // Scoreboard of expected checksum after each accepted word.
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_acc;
  logic [WIDTH-1:0] exp_val;

  xor_checksum_acc #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .seed     (seed),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .checksum (checksum),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid && in_ready) xfer_cnt++;
    if (done)     done_cnt++;
    if (busy)     busy_cnt++;
    if (in_ready) ready_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    xfer_cnt  = 0;
    done_cnt  = 0;
    busy_cnt  = 0;
    ready_cnt = 0;
  endtask

  // Called at #1 after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [WIDTH-1:0] s, input logic [LEN_W-1:0] l);
    start = 1'b1;
    seed  = s;
    len   = l;
    exp_acc = s;
    tick(1);
    start = 1'b0;
  endtask

  // Offer one word, wait (bounded) for acceptance, then score the checksum.
  task automatic send_word(input logic [WIDTH-1:0] w);
    int waited;
    in_valid = 1'b1;
    in_data  = w;
    exp_acc  = exp_acc ^ w;
    exp_q.push_back(exp_acc);
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick(1);
      waited++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      void'(exp_q.pop_front());
    end else begin
      tick(1);
      in_valid = 1'b0;
      exp_val = exp_q.pop_front();
      chk("xfer_checksum", 32'(checksum), 32'(exp_val));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    len      = '0;
    seed     = '0;
    in_valid = 1'b0;
    in_data  = '0;
    #3;
    chk("rst_checksum", 32'(checksum), 32'h0);
    chk("rst_count",    32'(count),    32'h0);
    chk("rst_busy",     32'(busy),     32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);

    // Basic XOR, back-to-back words.
    clear_mon();
    do_start(4'b0000, 4'd2);
    chk("t2_ready_lat", 32'(in_ready), 32'd1);
    send_word(4'b1010);
    chk("t2_busy_mid", 32'(busy), 32'd1);
    send_word(4'b0101);
    chk("t2_done",     32'(done),     32'd1);
    chk("t2_ready_dn", 32'(in_ready), 32'd0);
    chk("t2_count",    32'(count),    32'd2);
    tick(1);
    chk("t2_done_off", 32'(done),     32'd0);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_busy_cnt", 32'(busy_cnt), 32'd2);
    chk("t2_final",    32'(checksum), 32'b1111);

    // Seeded single-word run, result held in IDLE.
    do_start(4'b1111, 4'd1);
    send_word(4'b1010);
    chk("t3_done",     32'(done),     32'd1);
    chk("t3_ready_dn", 32'(in_ready), 32'd0);
    tick(5);
    chk("t3_hold",     32'(checksum), 32'b0101);
    chk("t3_idle",     32'(busy),     32'd0);

    // Zero-length run.
    clear_mon();
    do_start(4'b0110, 4'd0);
    chk("t4_done",     32'(done),      32'd1);
    chk("t4_checksum", 32'(checksum),  32'b0110);
    chk("t4_count",    32'(count),     32'd0);
    tick(2);
    chk("t4_no_ready", 32'(ready_cnt), 32'd0);

    // Gaps between words, start pulsed mid-run.
    clear_mon();
    do_start(4'b0000, 4'd3);
    send_word(4'b0001);
    tick(1);
    start = 1'b1;
    seed  = 4'b1111;
    len   = 4'd5;
    tick(1);
    start = 1'b0;
    send_word(4'b0010);
    tick(2);
    in_data = 4'b1111;  // don't-care while in_valid is low
    send_word(4'b0100);
    chk("t5_done",     32'(done),     32'd1);
    tick(4);
    chk("t5_checksum", 32'(checksum), 32'b0111);
    chk("t5_xfers",    32'(xfer_cnt), 32'd3);
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);
    chk("t5_no_rstrt", 32'(busy),     32'd0);

    // Reset mid-run, asserted between edges.
    do_start(4'b0000, 4'd3);
    send_word(4'b1100);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_checksum", 32'(checksum), 32'h0);
    chk("t6_count",    32'(count),    32'h0);
    chk("t6_busy",     32'(busy),     32'h0);
    chk("t6_done",     32'(done),     32'h0);
    chk("t6_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    chk("t6_idle", 32'(busy), 32'd0);
    do_start(4'b0011, 4'd1);
    send_word(4'b0001);
    chk("t6_final", 32'(checksum), 32'b0010);
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
